mem_access_unit: RTL and testbench

MEM stage of the 5-stage pipeline, directly downstream of EX. Captures the EX outputs and runs byte, halfword and word loads/stores over a ready-handshaked data-RAM port. It aligns and sign- or zero-extends load data and drives the registered result to WB. It stalls the upstream pipeline while a RAM transaction is outstanding and flags misaligned addresses.

---
 rtl/mem_access_unit_pkg.sv | 18 +
 rtl/mem_access_unit_align.sv | 55 +++++
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared widths, access-size encodings and FSM states
// for the MEM stage.
package mem_access_unit_pkg;

  localparam int ADDR_BUS     = 32;
  localparam int DATA_BUS     = 32;
  localparam int REG_ADDR_BUS = 5;

  localparam logic [3:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [3:0] MEM_SEL_HALF = 4'b0011;
  localparam logic [3:0] MEM_SEL_WORD = 4'b1111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_align.sv
// Lane replication, byte strobes, load extraction/extension
// and misalignment detection for one access.
module mem_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = DATA_BUS
) (
  input  logic [3:0]        sel,
  input  logic [1:0]        addr_lo,
  input  logic              sign,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] read_data,
  output logic [3:0]        strobe,
  output logic [DATA_W-1:0] store_word,
  output logic [DATA_W-1:0] load_word,
  output logic              misaligned
);

  logic              is_byte;
  logic              is_half;
  logic [3:0]        mask;
  logic [DATA_W-1:0] shifted;

  assign is_byte = (sel == MEM_SEL_BYTE);
  assign is_half = (sel == MEM_SEL_HALF);
  assign shifted = read_data >> {addr_lo, 3'b000};

  // Illegal size encodings fall through to word.
  always_comb begin
    mask       = 4'b1111;
    store_word = store_data;
    load_word  = read_data;
    misaligned = |addr_lo;
    unique case (1'b1)
      is_byte: begin
        mask       = 4'b0001;
        store_word = {4{store_data[7:0]}};
        load_word  = {{(DATA_W-8){sign & shifted[7]}},
                      shifted[7:0]};
        misaligned = 1'b0;
      end
      is_half: begin
        mask       = 4'b0011;
        store_word = {2{store_data[15:0]}};
        load_word  = {{(DATA_W-16){sign & shifted[15]}},
                      shifted[15:0]};
        misaligned = addr_lo[0];
      end
      default: ;
    endcase
  end

  assign strobe = mask << addr_lo;

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: captures the EX op, runs one handshaked
// data-RAM transaction per load/store and registers the WB result.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS,
  parameter int DATA_W = DATA_BUS,
  parameter int REG_AW = REG_ADDR_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_read_flag_in,
  input  logic              mem_write_flag_in,
  input  logic              mem_sign_flag_in,
  input  logic [3:0]        mem_sel_in,
  input  logic [DATA_W-1:0] mem_write_data_in,
  input  logic [ADDR_W-1:0] result_in,
  input  logic              reg_write_en_in,
  input  logic [REG_AW-1:0] reg_write_addr_in,
  input  logic [ADDR_W-1:0] current_pc_addr_in,
  output logic              stall_req,
  output logic              mem_load_flag,
  output logic              ram_en,
  output logic [3:0]        ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [DATA_W-1:0] result,
  output logic              reg_write_en_out,
  output logic [REG_AW-1:0] reg_write_addr_out,
  output logic [ADDR_W-1:0] current_pc_addr_out,
  output logic              addr_error,
  output logic [ADDR_W-1:0] bad_addr
);

  mau_state_e        state_q, state_d;
  logic              busy;
  logic              mem_op;
  logic              store_q;
  logic              sign_q;
  logic [3:0]        sel_q;
  logic [3:0]        strobe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wen_q;
  logic [REG_AW-1:0] waddr_q;
  logic [ADDR_W-1:0] pc_q;

  logic [3:0]        al_sel;
  logic [1:0]        al_lo;
  logic              al_sign;
  logic [3:0]        al_strobe;
  logic [DATA_W-1:0] al_store;
  logic [DATA_W-1:0] al_load;
  logic              al_mis;

  assign busy   = (state_q == S_BUSY);
  assign mem_op = mem_read_flag_in | mem_write_flag_in;

  // Capture decodes the incoming op; BUSY decodes the latched one.
  assign al_sel  = busy ? sel_q         : mem_sel_in;
  assign al_lo   = busy ? addr_q[1:0]   : result_in[1:0];
  assign al_sign = busy ? sign_q        : mem_sign_flag_in;

  mem_align #(.DATA_W(DATA_W)) u_align (
    .sel        (al_sel),
    .addr_lo    (al_lo),
    .sign       (al_sign),
    .store_data (mem_write_data_in),
    .read_data  (ram_read_data),
    .strobe     (al_strobe),
    .store_word (al_store),
    .load_word  (al_load),
    .misaligned (al_mis)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    stall_req = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!flush && mem_op && !al_mis) begin
          state_d   = S_BUSY;
          stall_req = 1'b1;
        end
      end
      S_BUSY: begin
        stall_req = !ram_ready;
        if (ram_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      store_q  <= 1'b0;
      sign_q   <= 1'b0;
      sel_q    <= '0;
      strobe_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      pc_q     <= '0;
    end else if (!busy && !flush && mem_op && !al_mis) begin
      store_q  <= mem_write_flag_in;
      sign_q   <= mem_sign_flag_in;
      sel_q    <= mem_sel_in;
      strobe_q <= mem_write_flag_in ? al_strobe : 4'b0000;
      addr_q   <= result_in;
      wdata_q  <= al_store;
      wen_q    <= reg_write_en_in;
      waddr_q  <= reg_write_addr_in;
      pc_q     <= current_pc_addr_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result              <= '0;
      reg_write_en_out    <= 1'b0;
      reg_write_addr_out  <= '0;
      current_pc_addr_out <= '0;
      addr_error          <= 1'b0;
      bad_addr            <= '0;
    end else begin
      addr_error       <= 1'b0;
      reg_write_en_out <= 1'b0;
      if (busy) begin
        if (ram_ready) begin
          result              <= store_q ? addr_q : al_load;
          reg_write_en_out    <= !store_q && wen_q;
          reg_write_addr_out  <= waddr_q;
          current_pc_addr_out <= pc_q;
        end
      end else if (!flush) begin
        if (mem_op && al_mis) begin
          addr_error <= 1'b1;
          bad_addr   <= result_in;
        end else if (!mem_op) begin
          result              <= result_in;
          reg_write_en_out    <= reg_write_en_in;
          reg_write_addr_out  <= reg_write_addr_in;
          current_pc_addr_out <= current_pc_addr_in;
        end
      end
    end
  end

  assign mem_load_flag  = busy && !store_q;
  assign ram_en         = busy;
  assign ram_write_en   = busy ? strobe_q : 4'b0000;
  assign ram_addr       = {addr_q[ADDR_W-1:2], 2'b00};
  assign ram_write_data = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: pass-through, loads,
// stores with wait states, misalignment, flush and mid-op reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        mem_read_flag_in;
  logic        mem_write_flag_in;
  logic        mem_sign_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_write_data_in;
  logic [31:0] result_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic [31:0] current_pc_addr_in;
  logic        stall_req;
  logic        mem_load_flag;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        ram_ready;
  logic [31:0] ram_read_data;
  logic [31:0] result;
  logic        reg_write_en_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] current_pc_addr_out;
  logic        addr_error;
  logic [31:0] bad_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .mem_read_flag_in    (mem_read_flag_in),
    .mem_write_flag_in   (mem_write_flag_in),
    .mem_sign_flag_in    (mem_sign_flag_in),
    .mem_sel_in          (mem_sel_in),
    .mem_write_data_in   (mem_write_data_in),
    .result_in           (result_in),
    .reg_write_en_in     (reg_write_en_in),
    .reg_write_addr_in   (reg_write_addr_in),
    .current_pc_addr_in  (current_pc_addr_in),
    .stall_req           (stall_req),
    .mem_load_flag       (mem_load_flag),
    .ram_en              (ram_en),
    .ram_write_en        (ram_write_en),
    .ram_addr            (ram_addr),
    .ram_write_data      (ram_write_data),
    .ram_ready           (ram_ready),
    .ram_read_data       (ram_read_data),
    .result              (result),
    .reg_write_en_out    (reg_write_en_out),
    .reg_write_addr_out  (reg_write_addr_out),
    .current_pc_addr_out (current_pc_addr_out),
    .addr_error          (addr_error),
    .bad_addr            (bad_addr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nop();
    flush              = 1'b0;
    mem_read_flag_in   = 1'b0;
    mem_write_flag_in  = 1'b0;
    mem_sign_flag_in   = 1'b0;
    mem_sel_in         = 4'b1111;
    mem_write_data_in  = '0;
    result_in          = '0;
    reg_write_en_in    = 1'b0;
    reg_write_addr_in  = '0;
    current_pc_addr_in = '0;
  endtask

  task automatic alu_op(input logic [31:0] res,
                        input logic [4:0]  ra,
                        input logic [31:0] pc);
    @(negedge clk);
    nop();
    result_in          = res;
    reg_write_en_in    = 1'b1;
    reg_write_addr_in  = ra;
    current_pc_addr_in = pc;
    #1 chk("alu_stall", stall_req, 0);
    @(negedge clk);
    chk("alu_result", result, res);
    chk("alu_wen", reg_write_en_out, 1);
    chk("alu_waddr", reg_write_addr_out, ra);
    chk("alu_pc", current_pc_addr_out, pc);
    chk("alu_stall2", stall_req, 0);
  endtask

  // One aligned access; waits = RAM wait cycles before ready.
  task automatic mem_txn(input string tag,
                         input logic rd, input logic wr,
                         input logic sg, input logic [3:0] sel,
                         input logic [31:0] wdata,
                         input logic [31:0] addr,
                         input int waits,
                         input logic [31:0] rdata,
                         input logic [3:0]  exp_we,
                         input logic [31:0] exp_wd,
                         input logic [31:0] exp_res,
                         input logic exp_wen);
    int stalls;
    @(negedge clk);
    nop();
    mem_read_flag_in   = rd;
    mem_write_flag_in  = wr;
    mem_sign_flag_in   = sg;
    mem_sel_in         = sel;
    mem_write_data_in  = wdata;
    result_in          = addr;
    reg_write_en_in    = 1'b1;
    reg_write_addr_in  = 5'd7;
    current_pc_addr_in = 32'h0000_0400;
    #1 chk({tag, "_stall_cap"}, stall_req, 1);
    stalls = 1;
    @(posedge clk);
    #1 nop();
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk({tag, "_ram_en"}, ram_en, 1);
      chk({tag, "_ram_addr"}, ram_addr, {addr[31:2], 2'b00});
      chk({tag, "_ram_we"}, ram_write_en, exp_we);
      if (wr) chk({tag, "_ram_wd"}, ram_write_data, exp_wd);
      chk({tag, "_bubble"}, reg_write_en_out, 0);
      chk({tag, "_ld_flag"}, mem_load_flag, !wr);
      ram_ready     = (i == waits);
      ram_read_data = (i == waits) ? rdata : 32'h0;
      #1 if (stall_req) stalls++;
    end
    @(posedge clk);
    #1 ram_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_stalls"}, stalls, waits + 1);
    chk({tag, "_ram_idle"}, ram_en, 0);
    chk({tag, "_wen"}, reg_write_en_out, exp_wen);
    chk({tag, "_waddr"}, reg_write_addr_out, 7);
    chk({tag, "_pc"}, current_pc_addr_out, 32'h0000_0400);
    if (rd && !wr) chk({tag, "_result"}, result, exp_res);
  endtask

  initial begin
    nop();
    rst           = 1'b0;
    ram_ready     = 1'b0;
    ram_read_data = '0;
    @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_wen", reg_write_en_out, 0);
    chk("rst_waddr", reg_write_addr_out, 0);
    chk("rst_pc", current_pc_addr_out, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_write_en, 0);
    chk("rst_bad", bad_addr, 0);
    chk("rst_err", addr_error, 0);
    chk("rst_stall", stall_req, 0);
    rst = 1'b1;

    alu_op(32'h0000_0005, 5'd3, 32'h0000_0100);

    mem_txn("lw", 1, 0, 0, 4'b1111, 32'h0, 32'h1000_0004,
            0, 32'hDEAD_BEEF, 4'b0000, 32'h0,
            32'hDEAD_BEEF, 1);
    mem_txn("lb", 1, 0, 1, 4'b0001, 32'h0, 32'h1000_0003,
            1, 32'h8012_3456, 4'b0000, 32'h0,
            32'hFFFF_FF80, 1);
    mem_txn("lbu", 1, 0, 0, 4'b0001, 32'h0, 32'h1000_0003,
            0, 32'h8012_3456, 4'b0000, 32'h0,
            32'h0000_0080, 1);
    mem_txn("lh", 1, 0, 1, 4'b0011, 32'h0, 32'h1000_0002,
            0, 32'h9ABC_1234, 4'b0000, 32'h0,
            32'hFFFF_9ABC, 1);
    mem_txn("sh", 0, 1, 0, 4'b0011, 32'h0000_ABCD, 32'h2000_0002,
            3, 32'h0, 4'b1100, 32'hABCD_ABCD,
            32'h0, 0);
    mem_txn("sb", 0, 1, 0, 4'b0001, 32'h0000_0077, 32'h2000_0001,
            0, 32'h0, 4'b0010, 32'h7777_7777,
            32'h0, 0);
    mem_txn("rdwr", 1, 1, 0, 4'b1111, 32'h1234_5678, 32'h2000_0008,
            0, 32'h0, 4'b1111, 32'h1234_5678,
            32'h0, 0);

    // Misaligned word load
    @(negedge clk);
    nop();
    mem_read_flag_in  = 1'b1;
    mem_sel_in        = 4'b1111;
    result_in         = 32'h1000_0001;
    reg_write_en_in   = 1'b1;
    reg_write_addr_in = 5'd4;
    #1 chk("mis_stall", stall_req, 0);
    @(negedge clk);
    chk("mis_err", addr_error, 1);
    chk("mis_bad", bad_addr, 32'h1000_0001);
    chk("mis_wen", reg_write_en_out, 0);
    chk("mis_ram_en", ram_en, 0);
    nop();
    @(negedge clk);
    chk("mis_err_pulse", addr_error, 0);
    chk("mis_bad_hold", bad_addr, 32'h1000_0001);
    chk("mis_ram_en2", ram_en, 0);

    // Flushed load is dropped
    @(negedge clk);
    nop();
    flush            = 1'b1;
    mem_read_flag_in = 1'b1;
    result_in        = 32'h1000_0010;
    reg_write_en_in  = 1'b1;
    #1 chk("flush_stall", stall_req, 0);
    @(negedge clk);
    chk("flush_ram_en", ram_en, 0);
    chk("flush_wen", reg_write_en_out, 0);
    nop();

    // Reset while BUSY
    @(negedge clk);
    mem_read_flag_in = 1'b1;
    result_in        = 32'h1000_0020;
    reg_write_en_in  = 1'b1;
    @(posedge clk);
    #1 nop();
    @(negedge clk);
    chk("rb_ram_en", ram_en, 1);
    rst = 1'b0;
    #1;
    chk("rb_ram_en_off", ram_en, 0);
    chk("rb_ld_flag", mem_load_flag, 0);
    chk("rb_stall", stall_req, 0);
    #1 rst = 1'b1;
    alu_op(32'h0000_0022, 5'd9, 32'h0000_0200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
